// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Line = 16 bytes (four 32-bit words); state codes are exported as plain constants too.
package dcache_pkg;

    localparam int OFFSET_BITS    = 4;
    localparam int LINE_BITS      = 128;
    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_SEL_MSB   = 3;
    localparam int WORD_SEL_LSB   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_WB   = WB;
    localparam logic [1:0] ST_FILL = FILL;

    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [1:0]           sel);
        return line[{sel, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the data cache.
// The cache attaches through the slave modport; the pipeline/memory environment uses master.
interface dcache_if;

    logic [31:0]                    cpu_addr_i;
    logic                           cpu_rd_i;
    logic                           cpu_wr_i;
    logic [31:0]                    cpu_wdata_i;
    logic [31:0]                    cpu_rdata_o;
    logic                           cpu_stall_o;

    logic                           mem_req_o;
    logic                           mem_we_o;
    logic [31:0]                    mem_addr_o;
    logic [dcache_pkg::LINE_BITS-1:0] mem_wdata_o;
    logic [dcache_pkg::LINE_BITS-1:0] mem_rdata_i;
    logic                           mem_ack_i;

    logic [31:0]                    hit_cnt_o;
    logic [31:0]                    miss_cnt_o;

    modport slave (
        input  cpu_addr_i, cpu_rd_i, cpu_wr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output hit_cnt_o, miss_cnt_o
    );

    modport master (
        output cpu_addr_i, cpu_rd_i, cpu_wr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  hit_cnt_o, miss_cnt_o
    );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: combinational read so hits resolve in the
// MEM cycle; synchronous line-fill and word-write ports; valid/dirty cleared on rst_i.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 5
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [INDEX_BITS-1:0]              idx,
    output logic [31-INDEX_BITS-OFFSET_BITS:0] rd_tag,
    output logic                               rd_valid,
    output logic                               rd_dirty,
    output logic [LINE_BITS-1:0]               rd_line,
    input  logic                               fill_en,
    input  logic [31-INDEX_BITS-OFFSET_BITS:0] fill_tag,
    input  logic [LINE_BITS-1:0]               fill_line,
    input  logic                               word_en,
    input  logic [1:0]                         word_sel,
    input  logic [31:0]                        word_data,
    input  logic                               clean_en
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;

    logic [TAG_BITS-1:0] tag_mem [LINES];
    logic [LINES-1:0]    valid_reg;
    logic [LINES-1:0]    dirty_reg;

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_mem[idx] <= fill_tag;
        end
    end

    // A fill always leaves the line clean; a word write marks it dirty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (fill_en) begin
            valid_reg[idx] <= 1'b1;
            dirty_reg[idx] <= 1'b0;
        end else if (word_en) begin
            dirty_reg[idx] <= 1'b1;
        end else if (clean_en) begin
            dirty_reg[idx] <= 1'b0;
        end
    end

    assign rd_tag   = tag_mem[idx];
    assign rd_valid = valid_reg[idx];
    assign rd_dirty = dirty_reg[idx];

    genvar gi;
    generate
        for (gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
            logic [31:0] word_mem [LINES];

            always_ff @(posedge clk_i) begin
                if (fill_en) begin
                    word_mem[idx] <= fill_line[gi*32 +: 32];
                end else if (word_en && (word_sel == 2'(gi))) begin
                    word_mem[idx] <= word_data;
                end
            end

            assign rd_line[gi*32 +: 32] = word_mem[idx];
        end
    endgenerate

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller: hit logic, WB/FILL FSM,
// registered memory handshake. Optional hit/miss counters under `DCACHE_STATS_EN.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 5
) (
    input  logic     clk_i,
    input  logic     rst_i,
    dcache_if.slave  bus
);

    localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;

    logic [TAG_BITS-1:0]   cpu_tag;
    logic [INDEX_BITS-1:0] cpu_idx;
    logic [1:0]            word_sel;
    logic                  unused_addr_bits;

    logic [TAG_BITS-1:0]   rd_tag;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic [LINE_BITS-1:0]  rd_line;

    logic                  access;
    logic                  hit;
    logic                  idle;
    logic                  miss;
    logic                  word_en;
    logic                  fill_en;
    logic                  clean_en;

    logic [1:0]            state_reg,  state_next;
    logic                  req_reg,    req_next;
    logic                  we_reg,     we_next;
    logic [31:0]           addr_reg,   addr_next;
    logic [LINE_BITS-1:0]  wdata_reg,  wdata_next;

    assign cpu_tag          = bus.cpu_addr_i[31 -: TAG_BITS];
    assign cpu_idx          = bus.cpu_addr_i[OFFSET_BITS +: INDEX_BITS];
    assign word_sel         = bus.cpu_addr_i[WORD_SEL_MSB:WORD_SEL_LSB];
    assign unused_addr_bits = &{1'b0, bus.cpu_addr_i[1:0]};

    assign access = bus.cpu_rd_i | bus.cpu_wr_i;
    assign hit    = rd_valid && (rd_tag == cpu_tag);
    assign idle   = (state_reg == ST_IDLE);
    assign miss   = idle && access && !hit;

    // A store wins when rd and wr are both high, so only a pure load returns data.
    assign word_en  = idle && bus.cpu_wr_i && hit && !rst_i;
    assign fill_en  = (state_reg == ST_FILL) && bus.mem_ack_i && !rst_i;
    assign clean_en = (state_reg == ST_WB) && bus.mem_ack_i && !rst_i;

    assign bus.cpu_stall_o = !idle || miss;
    assign bus.cpu_rdata_o = (idle && bus.cpu_rd_i && !bus.cpu_wr_i && hit)
                           ? line_word(rd_line, word_sel) : 32'd0;

    dcache_sram #(
        .INDEX_BITS (INDEX_BITS)
    ) u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idx       (cpu_idx),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_line   (rd_line),
        .fill_en   (fill_en),
        .fill_tag  (cpu_tag),
        .fill_line (bus.mem_rdata_i),
        .word_en   (word_en),
        .word_sel  (word_sel),
        .word_data (bus.cpu_wdata_i),
        .clean_en  (clean_en)
    );

    // Memory outputs are registered alongside the state so they are glitch-free and hold
    // until ack; req stays up across WB->FILL, only address and we change.
    always_comb begin
        state_next = state_reg;
        req_next   = req_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (miss) begin
                    req_next = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_next = ST_WB;
                        we_next    = 1'b1;
                        addr_next  = {rd_tag, cpu_idx, {OFFSET_BITS{1'b0}}};
                        wdata_next = rd_line;
                    end else begin
                        state_next = ST_FILL;
                        we_next    = 1'b0;
                        addr_next  = {cpu_tag, cpu_idx, {OFFSET_BITS{1'b0}}};
                    end
                end
            end
            ST_WB: begin
                if (bus.mem_ack_i) begin
                    state_next = ST_FILL;
                    we_next    = 1'b0;
                    addr_next  = {cpu_tag, cpu_idx, {OFFSET_BITS{1'b0}}};
                end
            end
            ST_FILL: begin
                if (bus.mem_ack_i) begin
                    state_next = ST_IDLE;
                    req_next   = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            req_reg   <= req_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    assign bus.mem_req_o   = req_reg;
    assign bus.mem_we_o    = we_reg;
    assign bus.mem_addr_o  = addr_reg;
    assign bus.mem_wdata_o = wdata_reg;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;
    logic        replay_reg;

    // replay_reg marks the IDLE cycle right after a fill so the replayed hit is not counted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
            replay_reg   <= 1'b0;
        end else begin
            if (idle && access && hit && !replay_reg) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end
            if (miss) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
            replay_reg <= fill_en;
        end
    end

    assign bus.hit_cnt_o  = hit_cnt_reg;
    assign bus.miss_cnt_o = miss_cnt_reg;
`else
    assign bus.hit_cnt_o  = 32'd0;
    assign bus.miss_cnt_o = 32'd0;
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and a slow line-wide data memory.
- Hits complete in the MEM cycle with no stall.
- Misses assert cpu_stall_o, write back a dirty victim if needed, refill the line over a req/ack handshake, then replay the access as a hit.

Parameters:
- INDEX_BITS, 5, log2 of line count (32 lines); tag width = 32 - INDEX_BITS - 4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cpu_addr_i  in  32  byte address; bits [1:0] ignored, [3:2] word select
- cpu_rd_i  in  1  load request
- cpu_wr_i  in  1  store request
- cpu_wdata_i  in  32  store data
- cpu_rdata_o  out  32  load data, valid when cpu_rd_i=1 and cpu_stall_o=0
- cpu_stall_o  out  1  freeze pipeline, combinational
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = line write-back, 0 = line fill
- mem_addr_o  out  32  line address, bits [3:0] = 0
- mem_wdata_o  out  128  victim line
- mem_rdata_i  in  128  fill line
- mem_ack_i  in  1  one-cycle completion pulse
- hit_cnt_o  out  32  hit counter (DCACHE_STATS_EN)
- miss_cnt_o  out  32  miss counter (DCACHE_STATS_EN)

Behaviour:
- Clocking: one clock, clk_i. rst_i is synchronous, active-high.
- Reset:
  - state=IDLE; all valid and dirty bits cleared.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - cpu_rdata_o=0; counters=0.
  - cpu_stall_o=0 while no request is presented.
- Access: access = cpu_rd_i | cpu_wr_i. If both are high, treat it as a write.
- hit = valid[idx] & (tag[idx] == addr tag).
- IDLE state:
  - Read hit: cpu_rdata_o = data[idx][word] combinationally; stall=0.
  - Write hit: at the clock edge, write the word into the line and set dirty[idx]=1; stall=0.
  - Miss (access & !hit):
    - cpu_stall_o=1 in the same cycle.
    - Next state is WB if valid & dirty, else FILL.
  - No access: cpu_rdata_o=0, stall=0.
- WB state:
  - Drives mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, idx, 4'b0}, mem_wdata_o=victim line.
  - On mem_ack_i: clear dirty; go to FILL.
- FILL state:
  - Drives mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag, idx, 4'b0}.
  - On mem_ack_i: write mem_rdata_i into the line, set the tag, valid=1, dirty=0; go to IDLE.
- cpu_stall_o is 1 throughout WB and FILL.
- Replay: in the first IDLE cycle after a fill the access hits, stall drops, and a store is merged then (dirty=1).
- Clean miss latency: 1 + memory latency + 1 cycles of stall.
- Handshake rules:
  - mem_req_o and the address/data outputs are Moore outputs, registered from state.
  - They stay stable until ack is sampled; mem_req_o deasserts in the cycle after ack.
  - WB and FILL are two separate transactions; req stays high across the WB to FILL boundary, and only the address and mem_we_o change.
  - mem_ack_i is ignored in IDLE.
- CPU contract: the CPU holds addr, rd, wr and wdata stable while cpu_stall_o=1. The cache re-evaluates the request each IDLE cycle.
- Reset mid-transaction: the FSM returns to IDLE and mem_req_o=0 in the next cycle. All lines are invalidated; dirty data is discarded. A late ack has no effect.
- Index wrap: addresses that differ only in tag map to the same line and evict each other.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - hit_cnt_o increments once per access that hits on first presentation.
  - miss_cnt_o increments on each IDLE to WB/FILL transition.
  - The post-fill replay hit is not counted, tracked by a replay flag.
  - Both counters wrap modulo 2^32 and clear on reset.
- Undefined: hit_cnt_o and miss_cnt_o are tied to 0 and no counter logic is generated.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, WB, FILL}, 2 bits.
  - OFFSET_BITS=4, LINE_BITS=128, WORD_SEL range [3:2].
- Sub-module dcache_sram:
  - tag, valid, dirty and data arrays.
  - Combinational read; synchronous write with separate line-fill and word-write enables; synchronous clear of valid/dirty on rst_i.
- The dcache_ctrl top holds the FSM, hit logic, memory interface and counters.

Test Plan:
- Cold read: after reset, rd 0x0000_0040 with mem ack 3 cycles after req and rdata line {4{32'hA5A5_0000}}.
  - Expect stall for 5 cycles, one FILL request with mem_addr_o=0x40, then cpu_rdata_o=0xA5A5_0000.
  - Expect miss_cnt_o=1, hit_cnt_o=0.
- Hits: rd 0x44, then wr 0x48 data 0x1234_5678, then rd 0x48.
  - Expect zero stall, read returns 0x1234_5678, dirty[4]=1, hit_cnt_o=3.
- Dirty eviction: wr 0x0000_0048, then rd 0x0000_0248 (same index 4, different tag).
  - Expect a WB request at mem_addr_o=0x40 whose mem_wdata_o contains 0x1234_5678 in word 2.
  - Then a FILL at 0x240 (req held high across the boundary), then read data from the new line.
- Write miss: wr 0x0000_0080 data 0xDEAD_BEEF to a clean invalid line.
  - Expect FILL of 0x80, the store merged on replay, and a later rd 0x80 returning 0xDEAD_BEEF with no stall.
- Reset mid-FILL: assert rst_i one cycle while mem_req_o=1, then pulse ack.
  - Expect mem_req_o=0 the next cycle, no array update, and rd 0x40 missing again.
- rd and wr both high on a hit at 0x44 with data 0x0F0F_0F0F.
  - Expect write behaviour only; a subsequent read returns 0x0F0F_0F0F.
